// File: rtl/fifo_word_unpacker_if.sv
// rtl/fifo_word_unpacker_if.sv - word dequeue side and lane enqueue side of the unpacker
interface fifo_word_unpacker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8
);
    logic                  src_deq_ena;
    logic                  src_deq_rdy;
    logic [DATA_WIDTH-1:0] src_first;
    logic                  src_first_rdy;
    logic                  dst_enq_ena;
    logic [LANE_WIDTH-1:0] dst_enq_v;
    logic                  dst_enq_rdy;

    modport master (
        output src_deq_ena,
        input  src_deq_rdy,
        input  src_first,
        input  src_first_rdy,
        output dst_enq_ena,
        output dst_enq_v,
        input  dst_enq_rdy
    );

    modport slave (
        input  src_deq_ena,
        output src_deq_rdy,
        output src_first,
        output src_first_rdy,
        input  dst_enq_ena,
        input  dst_enq_v,
        output dst_enq_rdy
    );
endinterface

// File: rtl/fifo_word_unpacker.sv
// rtl/fifo_word_unpacker.sv - dequeues words from a FIFO and emits them one lane per cycle
module fifo_word_unpacker #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    fifo_word_unpacker_if.master  bus,
    output logic                  busy,
    output logic [15:0]           word_count
);
    localparam int NLANES    = DATA_WIDTH / LANE_WIDTH;
    localparam int LANE_BITS = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NLANES - 1);

    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] hold_shifted;
    logic [LANE_BITS-1:0]  lane;
    logic                  valid;
    logic                  lane_accept;
    logic                  last_accept;
    logic                  can_load;
    logic                  load;

    // A refill may coincide with the last-lane accept, so words stream without a bubble.
    always_comb begin
        lane_accept = valid & bus.dst_enq_rdy & ~RST;
        last_accept = lane_accept & (lane == LAST_LANE);
        can_load    = ~valid | last_accept;
        load        = can_load & bus.src_deq_rdy & bus.src_first_rdy & ~RST;
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign bus.dst_enq_v = hold[DATA_WIDTH-1 -: LANE_WIDTH];
            assign hold_shifted  = hold << LANE_WIDTH;
        end else begin : g_lsb_first
            assign bus.dst_enq_v = hold[LANE_WIDTH-1:0];
            assign hold_shifted  = hold >> LANE_WIDTH;
        end
    endgenerate

    assign bus.src_deq_ena = load;
    assign bus.dst_enq_ena = lane_accept;
    assign busy            = valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold       <= '0;
            lane       <= '0;
            valid      <= 1'b0;
            word_count <= '0;
        end else begin
            if (load) begin
                hold  <= bus.src_first;
                lane  <= '0;
                valid <= 1'b1;
            end else if (lane_accept) begin
                hold <= hold_shifted;
                // Lane index returns to zero explicitly so non-power-of-two lane counts work.
                lane <= last_accept ? '0 : lane + 1'b1;
                if (last_accept) begin
                    valid <= 1'b0;
                end
            end
            if (last_accept) begin
                word_count <= word_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_unpacker.sv
// tb/tb_fifo_word_unpacker.sv - scoreboard bench for fifo_word_unpacker
module tb_fifo_word_unpacker;
    logic        CLK = 1'b0;
    logic        rst_m, rst_s, rst_w;
    logic        busy_m, busy_s, busy_w;
    logic [15:0] wc_m, wc_s, wc_w;

    always #5 CLK = ~CLK;

    fifo_word_unpacker_if #(.DATA_WIDTH(32), .LANE_WIDTH(8)) ifm ();
    fifo_word_unpacker_if #(.DATA_WIDTH(32), .LANE_WIDTH(8)) ifs ();
    fifo_word_unpacker_if #(.DATA_WIDTH(8),  .LANE_WIDTH(8)) ifw ();

    fifo_word_unpacker #(.DATA_WIDTH(32), .LANE_WIDTH(8), .MSB_FIRST(1'b0)) dut_m (
        .CLK(CLK), .RST(rst_m), .bus(ifm.master), .busy(busy_m), .word_count(wc_m));
    fifo_word_unpacker #(.DATA_WIDTH(32), .LANE_WIDTH(8), .MSB_FIRST(1'b1)) dut_s (
        .CLK(CLK), .RST(rst_s), .bus(ifs.master), .busy(busy_s), .word_count(wc_s));
    fifo_word_unpacker #(.DATA_WIDTH(8), .LANE_WIDTH(8), .MSB_FIRST(1'b0)) dut_w (
        .CLK(CLK), .RST(rst_w), .bus(ifw.master), .busy(busy_w), .word_count(wc_w));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          exp_wc   = 0;
    logic [31:0] src_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_s[$];
    int          enq_cyc[$];
    int          deq_cyc[$];
    bit          src_en   = 1'b1;
    bit          src_took = 1'b0;
    bit          wrap_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a word splits into four bytes, lowest first (or highest first for MSB order).
    task automatic push_m(input logic [31:0] w);
        logic [31:0] t;
        src_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            t = w >> (8 * i);
            exp_q.push_back(t[7:0]);
        end
    endtask

    task automatic drain_m(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            @(posedge CLK); #1;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_enq(input int n);
        for (int i = 0; i < 200 && enq_cyc.size() < n; i++) begin
            @(posedge CLK); #1;
        end
        chk("wait_lanes", (enq_cyc.size() >= n) ? 1 : 0, 1);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Upstream FIFO model for the main instance.
    always @(negedge CLK) src_took = ifm.src_deq_ena;
    always begin
        @(posedge CLK); #2;
        if (src_took && src_q.size() != 0) src_q.delete(0);
        ifm.src_deq_rdy   = (src_q.size() != 0);
        ifm.src_first_rdy = src_en && (src_q.size() != 0);
        ifm.src_first     = (src_q.size() != 0) ? src_q[0] : 32'h0;
    end

    // Scoreboard monitors.
    always @(negedge CLK) begin
        if (ifm.src_deq_ena) begin
            chk("deq_ena_needs_rdy", ifm.src_deq_rdy, 1);
            deq_cyc.push_back(cyc);
        end
        if (rst_m) chk("ena_in_reset", {ifm.src_deq_ena, ifm.dst_enq_ena}, 0);
        if (ifm.dst_enq_ena) begin
            chk("enq_ena_needs_rdy", ifm.dst_enq_rdy, 1);
            enq_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_lane: got 0x%0h required no lane", ifm.dst_enq_v);
            end else begin
                chk("lane", ifm.dst_enq_v, exp_q.pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        if (ifs.dst_enq_ena) begin
            if (exp_s.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_msb_lane: got 0x%0h required no lane", ifs.dst_enq_v);
            end else begin
                chk("msb_lane", ifs.dst_enq_v, exp_s.pop_front());
            end
        end
    end

    // Counter wrap: one-lane instance streams 65536 words whose value is their index mod 256.
    initial begin
        int  w_n = 0;
        int  w_err = 0;
        bit  took;
        bit  seen_ffff = 1'b0;
        rst_w = 1'b1;
        ifw.src_deq_rdy = 1'b1; ifw.src_first_rdy = 1'b1;
        ifw.dst_enq_rdy = 1'b1; ifw.src_first = 8'h00;
        repeat (2) @(posedge CLK);
        #1 rst_w = 1'b0;
        for (int c = 0; c < 70000 && w_n < 65536; c++) begin
            @(negedge CLK);
            took = ifw.src_deq_ena;
            if (ifw.dst_enq_ena) begin
                if (ifw.dst_enq_v !== w_n[7:0]) w_err++;
                w_n++;
            end
            @(posedge CLK); #1;
            if (took) ifw.src_first = ifw.src_first + 8'd1;
            if (w_n == 65535 && !seen_ffff) begin
                chk("wc_ffff", {16'h0, wc_w}, 32'hFFFF);
                seen_ffff = 1'b1;
            end
        end
        chk("wrap_words", w_n, 65536);
        chk("wc_wrapped", {16'h0, wc_w}, 0);
        chk("wrap_data_errs", w_err, 0);
        wrap_done = 1'b1;
    end

    initial begin
        logic [31:0] w;
        rst_m = 1'b1; rst_s = 1'b1;
        ifm.dst_enq_rdy = 1'b1;
        ifs.src_deq_rdy = 1'b0; ifs.src_first_rdy = 1'b0;
        ifs.src_first = 32'h0; ifs.dst_enq_rdy = 1'b1;

        // 1. reset with a word waiting upstream
        push_m(32'h11223344);
        repeat (2) @(posedge CLK);
        #1 rst_m = 1'b0; rst_s = 1'b0;
        @(negedge CLK);
        chk("rst_deq_first_cycle", ifm.src_deq_ena, 1);
        chk("rst_enq_v", ifm.dst_enq_v, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_wc", wc_m, 0);
        drain_m("rst_drain");
        exp_wc += 1;
        chk("rst_lane_latency", enq_cyc[0], deq_cyc[0] + 1);
        chk("rst_lanes_consec", enq_cyc[3] - enq_cyc[0], 3);
        chk("rst_wc_after", wc_m, exp_wc);
        chk("idle_busy", busy_m, 0);

        // 2. back-to-back words
        enq_cyc.delete(); deq_cyc.delete();
        push_m(32'hA1B2C3D4);
        push_m(32'h01020304);
        drain_m("b2b_drain");
        exp_wc += 2;
        chk("b2b_count", enq_cyc.size(), 8);
        chk("b2b_consec", enq_cyc[7] - enq_cyc[0], 7);
        chk("b2b_refill_on_last", deq_cyc[1], enq_cyc[3]);
        chk("b2b_wc", wc_m, exp_wc);

        // 3. backpressure after the first byte
        enq_cyc.delete(); deq_cyc.delete();
        push_m(32'hDEADBEEF);
        push_m(32'h12345678);
        wait_enq(1);
        ifm.dst_enq_rdy = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            chk("stall_v", ifm.dst_enq_v, 8'hBE);
            chk("stall_enq", ifm.dst_enq_ena, 0);
            chk("stall_deq", ifm.src_deq_ena, 0);
        end
        @(posedge CLK); #1 ifm.dst_enq_rdy = 1'b1;
        drain_m("bp_drain");
        exp_wc += 2;
        chk("bp_wc", wc_m, exp_wc);

        // 4. most-significant lane first
        w = 32'h11223344;
        for (int i = 0; i < 4; i++) exp_s.push_back(8'(w >> (8 * (3 - i))));
        ifs.src_first = w; ifs.src_deq_rdy = 1'b1; ifs.src_first_rdy = 1'b1;
        for (int i = 0; i < 20 && !ifs.src_deq_ena; i++) @(negedge CLK);
        chk("msb_deq", ifs.src_deq_ena, 1);
        @(posedge CLK); #1;
        ifs.src_deq_rdy = 1'b0; ifs.src_first_rdy = 1'b0;
        chk("msb_busy_hi", busy_s, 1);
        for (int i = 0; i < 50 && exp_s.size() != 0; i++) begin
            @(posedge CLK); #1;
        end
        chk("msb_drain", exp_s.size(), 0);
        chk("msb_busy_falls", busy_s, 0);
        chk("msb_wc", wc_s, 1);

        // 5. reset after two bytes of a word
        enq_cyc.delete();
        push_m(32'hCAFEF00D);
        wait_enq(2);
        rst_m = 1'b1;
        exp_q.delete();
        exp_wc = 0;
        @(negedge CLK);
        chk("midrst_enq", ifm.dst_enq_ena, 0);
        @(posedge CLK); #1 rst_m = 1'b0;
        @(negedge CLK);
        chk("midrst_busy", busy_m, 0);
        chk("midrst_wc", wc_m, 0);
        chk("midrst_no_lane", ifm.dst_enq_ena, 0);
        push_m(32'h00000055);
        drain_m("midrst_drain");
        exp_wc += 1;
        chk("midrst_wc_after", wc_m, exp_wc);

        // randomized traffic with upstream and downstream stalls
        for (int i = 0; i < 40; i++) push_m($urandom);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            @(posedge CLK); #1;
            ifm.dst_enq_rdy = ($urandom_range(0, 9) < 7);
            src_en = ($urandom_range(0, 9) < 8);
        end
        ifm.dst_enq_rdy = 1'b1; src_en = 1'b1;
        drain_m("rand_drain");
        exp_wc += 40;
        repeat (2) @(posedge CLK);
        #1 chk("rand_wc", wc_m, exp_wc);
        chk("rand_busy", busy_m, 0);

        for (int i = 0; i < 80000 && !wrap_done; i++) @(posedge CLK);
        chk("wrap_finished", wrap_done, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_word_unpacker.md
Name: fifo_word_unpacker

Overview:
- Consumer-side partner to the single-entry FIFO block. It drives the FIFO's dequeue interface: it samples `first`, then fires `deq`.
- It splits each dequeued DATA_WIDTH word into LANE_WIDTH lanes and pushes them, one per cycle, into a downstream enq-style interface.
- It sits between a word FIFO and a narrow (byte) sink, for example a UART or byte-stream packer.
- Method-call convention: the caller drives `__ENA`, the callee drives `__RDY`, and `__ENA` is asserted only while the matching `__RDY` is high.

Parameters:
- DATA_WIDTH, 32, width of the dequeued word; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, width of each emitted lane.
- MSB_FIRST, 0, 0 = emit the least-significant lane first, 1 = emit the most-significant lane first.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- src$deq__ENA  output  1  dequeue request to the upstream FIFO.
- src$deq__RDY  input  1  upstream FIFO can dequeue (FIFO holds a word).
- src$first  input  DATA_WIDTH  head word of the upstream FIFO.
- src$first__RDY  input  1  src$first is valid.
- dst$enq__ENA  output  1  enqueue of one lane into the downstream sink.
- dst$enq$v  output  LANE_WIDTH  lane value.
- dst$enq__RDY  input  1  downstream sink can accept.
- busy  output  1  a word is held and not yet fully emitted.
- word_count  output  16  number of words fully emitted; wraps 0xFFFF -> 0.

Behaviour:
- Constant: NLANES = DATA_WIDTH/LANE_WIDTH.
- State:
  - `hold`: shift register, DATA_WIDTH bits.
  - `lane`: index, clog2(NLANES) bits.
  - `valid`: flag.
  - `word_count`: 16-bit counter.
- Reset (RST high at a rising edge):
  - `valid`=0, `lane`=0, `hold`=0, `word_count`=0.
  - While RST is high: src$deq__ENA=0, dst$enq__ENA=0.
- Outputs after reset:
  - dst$enq$v=0, busy=0.
  - The first dequeue may occur in the first cycle with RST low.
- Emission:
  - dst$enq$v = current lane of `hold`: the low LANE_WIDTH bits when MSB_FIRST=0, the high bits when MSB_FIRST=1.
  - dst$enq__ENA = `valid` & dst$enq__RDY & !RST.
  - On each accepted lane, `hold` shifts by LANE_WIDTH toward the emitting end (zero fill) and `lane` increments.
- Last lane (`lane` = NLANES-1 and accepted):
  - `word_count` increments.
  - `valid` clears, unless a refill occurs in the same cycle.
- Dequeue/refill:
  - Condition: `can_load` = (!`valid` | last lane accepted this cycle).
  - src$deq__ENA = `can_load` & src$deq__RDY & src$first__RDY & !RST (combinational).
  - When src$deq__ENA=1: `hold` <= src$first, `lane` <= 0, `valid` <= 1.
- Latency:
  - A word dequeued at edge t has lane 0 offered in the cycle after t.
  - Sustained throughput is 1 lane/cycle; back-to-back words have no bubble, because a refill coincides with the last-lane accept.
- Backpressure:
  - dst$enq__RDY low stalls `hold` and `lane` indefinitely.
  - No dequeue occurs while a word is partially emitted.
- Empty upstream: with `valid`=0 and src$deq__RDY=0, the block idles and all ENAs stay low.
- busy = `valid`.
- Reset mid-word: the held word is discarded, no further lanes are emitted, and `word_count` is cleared.
- Invariant: src$deq__ENA is never high while src$deq__RDY is low; dst$enq__ENA is never high while dst$enq__RDY is low.

Test Plan:
1. **Reset.** Hold RST for 2 cycles with FIFO RDY=1 and first=0x11223344. Required: no ENA during reset. First deq fires in the first cycle after release. Bytes 0x44, 0x33, 0x22, 0x11 follow on 4 consecutive cycles; word_count=1.
2. **Back-to-back.** FIFO supplies 0xA1B2C3D4 then 0x01020304, dst RDY always 1. Required: 8 consecutive ENA cycles with values D4 C3 B2 A1 04 03 02 01. The second deq coincides with the A1 accept; word_count=2.
3. **Backpressure.** Word 0xDEADBEEF; dst RDY=0 for 5 cycles after the first byte. Required: dst$enq$v holds 0xBE with ENA low and no deq during the stall. Emission resumes with BE AD DE.
4. **MSB_FIRST=1.** Word 0x11223344. Required: 11 22 33 44 emitted; busy falls the cycle after the 0x44 accept when no refill occurs.
5. **Reset mid-word.** Word 0xCAFEF00D; assert RST after 2 bytes (0D F0) are emitted. Required: no further bytes, busy=0, word_count=0. The next word 0x00000055 emits 55 00 00 00.
6. **Counter wrap.** Preload by streaming 65536 words. Required: word_count reads 0x0000 after the 65536th word completes; data ordering is still correct.
